lii_stream_packer: RTL and testbench

// - Transmit end of the LII phy link: merges NIN kernel output streams onto one LII phy output channel.
// - Arbitrates round-robin, zero-extends each beat into PW bits and tags it with src/dst IDs.
// - Buffers through a 2-entry output FIFO; sits between HLS kernel outputs and the LII phy output port.

---
 rtl/lii_stream_packer.sv | 157 +++++++++++++++
 tb/tb_lii_stream_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lii_stream_packer.sv
// lii_stream_packer: round-robin merge of NIN kernel streams onto one LII phy output via a 2-entry FIFO.
// Optional macro LII_PACK_LAST_EN adds tlast ports and packet-locked arbitration.
module lii_stream_packer #(
  parameter int               NIN     = 2,
  parameter int               DW      = 32,
  parameter int               PW      = 64,
  parameter logic [7:0]       SRC_ID  = 8'h00,
  parameter logic [8*NIN-1:0] DST_IDS = 16'h0100
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NIN*DW-1:0] s_tdata,
  input  logic [NIN-1:0]    s_tvalid,
`ifdef LII_PACK_LAST_EN
  input  logic [NIN-1:0]    s_tlast,
`endif
  output logic [NIN-1:0]    s_tready,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
`ifdef LII_PACK_LAST_EN
  output logic              lii_out_p0_tlast,
`endif
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst
);

  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;

  if (DW > PW) begin : g_width_check
    $error("lii_stream_packer: DW (%0d) must not exceed PW (%0d)", DW, PW);
  end

  logic [IW-1:0] r_rr;
  logic [1:0]    r_count;
  logic          r_wptr;
  logic          r_rptr;
  logic [7:0]    r_src;
  logic [DW-1:0] r_fifo_data [2];
  logic [7:0]    r_fifo_dst  [2];
`ifdef LII_PACK_LAST_EN
  logic          r_fifo_last [2];
  logic          r_lock;
  logic [IW-1:0] r_lock_sel;
`endif

  logic [IW-1:0] w_scan_gnt;
  logic [IW-1:0] w_gnt;
  logic [IW-1:0] w_gnt_inc;
  logic          w_ready;
  logic          w_accept;
  logic          w_pop;
  logic [DW-1:0] w_in_data;
  logic [7:0]    w_in_dst;

  // Rotating priority scan: first valid stream at or after the rr pointer, mod NIN.
  always_comb begin : arb_scan
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_found;
    w_scan_gnt = r_rr;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < NIN; k++) begin
      w_sum      = {1'b0, r_rr} + (IW+1)'(k);
      w_idx      = (w_sum >= (IW+1)'(NIN)) ? IW'(w_sum - (IW+1)'(NIN)) : IW'(w_sum);
      w_scan_gnt = (!w_found && s_tvalid[w_idx]) ? w_idx : w_scan_gnt;
      w_found    = w_found | s_tvalid[w_idx];
    end
  end

`ifdef LII_PACK_LAST_EN
  assign w_gnt = r_lock ? r_lock_sel : w_scan_gnt;
`else
  assign w_gnt = w_scan_gnt;
`endif

  // Ready depends only on registered state and kernel valids, never on phy ready.
  assign w_ready   = !arst && (|s_tvalid) && (r_count < 2'd2);
  assign s_tready  = w_ready ? ({{(NIN-1){1'b0}}, 1'b1} << w_gnt) : {NIN{1'b0}};
  assign w_accept  = w_ready && s_tvalid[w_gnt];
  assign w_pop     = (r_count != 2'd0) && lii_out_p0_tready;
  assign w_gnt_inc = (w_gnt == IW'(NIN-1)) ? {IW{1'b0}} : (w_gnt + {{(IW-1){1'b0}}, 1'b1});
  assign w_in_data = s_tdata[DW*w_gnt +: DW];
  assign w_in_dst  = DST_IDS[8*w_gnt +: 8];

  // FIFO storage, occupancy, pointers and arbitration state.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_rr           <= {IW{1'b0}};
      r_count        <= 2'd0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_src          <= 8'h00;
      r_fifo_data[0] <= {DW{1'b0}};
      r_fifo_data[1] <= {DW{1'b0}};
      r_fifo_dst[0]  <= 8'h00;
      r_fifo_dst[1]  <= 8'h00;
`ifdef LII_PACK_LAST_EN
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_lock         <= 1'b0;
      r_lock_sel     <= {IW{1'b0}};
`endif
    end else begin
      r_src <= SRC_ID;
      if (w_accept) begin
        r_fifo_data[r_wptr] <= w_in_data;
        r_fifo_dst[r_wptr]  <= w_in_dst;
`ifdef LII_PACK_LAST_EN
        r_fifo_last[r_wptr] <= s_tlast[w_gnt];
`endif
        r_wptr <= ~r_wptr;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
`ifdef LII_PACK_LAST_EN
      // A packet holds the grant until its tlast beat; only then does rr advance.
      if (w_accept && s_tlast[w_gnt]) begin
        r_lock <= 1'b0;
        r_rr   <= w_gnt_inc;
      end else if (w_accept) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_gnt;
      end else begin
        r_lock <= r_lock;
      end
`else
      if (w_accept) begin
        r_rr <= w_gnt_inc;
      end else begin
        r_rr <= r_rr;
      end
`endif
    end
  end

  assign lii_out_p0_tvalid = (r_count != 2'd0);
  assign lii_out_p0_tdata  = PW'(r_fifo_data[r_rptr]);
  assign lii_out_p0_dst    = r_fifo_dst[r_rptr];
  assign lii_out_p0_src    = r_src;
`ifdef LII_PACK_LAST_EN
  assign lii_out_p0_tlast  = r_fifo_last[r_rptr];
`endif

endmodule

// File: tb/tb_lii_stream_packer.sv
// Directed self-checking bench for lii_stream_packer (NIN=2, DW=32, PW=64).
// The packet-lock scenario is compiled only when LII_PACK_LAST_EN is defined.
module tb_lii_stream_packer;

  logic        aclk = 1'b0;
  logic        arst;
  logic [63:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tready;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [7:0]  src;
  logic [7:0]  dst;
`ifdef LII_PACK_LAST_EN
  logic [1:0]  s_tlast;
  logic        tlast;
`endif

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  lii_stream_packer #(
    .NIN(2), .DW(32), .PW(64), .SRC_ID(8'h00), .DST_IDS(16'h0100)
  ) dut (
    .aclk              (aclk),
    .arst              (arst),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
`ifdef LII_PACK_LAST_EN
    .s_tlast           (s_tlast),
    .lii_out_p0_tlast  (tlast),
`endif
    .s_tready          (s_tready),
    .lii_out_p0_tdata  (tdata),
    .lii_out_p0_tvalid (tvalid),
    .lii_out_p0_tready (tready),
    .lii_out_p0_src    (src),
    .lii_out_p0_dst    (dst)
  );

  task automatic do_reset();
    @(negedge aclk);
    arst     = 1'b1;
    s_tvalid = 2'b00;
    tready   = 1'b0;
    @(posedge aclk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst     = 1'b1;
    tready   = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = {32'h0000_00B0, 32'h0000_00A0};
    @(negedge aclk);
    checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_tready got=%b exp=00", s_tready); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    checks++; if (dst !== 8'h00) begin errors++; $display("FAIL reset_dst got=%h exp=00", dst); end
    @(posedge aclk);
    #1;
    arst = 1'b0;
    @(negedge aclk);
    checks++; if (s_tready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=01", s_tready); end
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got=%b exp=1", tvalid); end
    checks++; if (tdata !== 64'h0000_0000_0000_00A0) begin errors++; $display("FAIL reset_first_data got=%h exp=a0", tdata); end
    checks++; if (dst !== 8'h00) begin errors++; $display("FAIL reset_first_dst got=%h exp=00", dst); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data [6] = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22};
    logic [7:0]  exp_dst  [6] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    logic [31:0] d0 = 32'h10;
    logic [31:0] d1 = 32'h20;
    logic [1:0]  acc;
    logic [1:0]  exp_rdy;
    do_reset();
    tready   = 1'b1;
    s_tvalid = 2'b11;
    for (int c = 0; c < 7; c++) begin
      s_tdata = {d1, d0};
      @(negedge aclk);
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (s_tready !== exp_rdy) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, s_tready, exp_rdy); end
      if (c > 0) begin
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, tvalid); end
        checks++; if (tdata !== {32'h0, exp_data[c-1]}) begin errors++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, tdata, {32'h0, exp_data[c-1]}); end
        checks++; if (dst !== exp_dst[c-1]) begin errors++; $display("FAIL rr_dst c=%0d got=%h exp=%h", c, dst, exp_dst[c-1]); end
        checks++; if (src !== 8'h00) begin errors++; $display("FAIL rr_src c=%0d got=%h exp=00", c, src); end
      end
      acc = s_tready & s_tvalid;
      @(posedge aclk);
      #1;
      if (acc[0]) d0 = d0 + 32'd1;
      if (acc[1]) d1 = d1 + 32'd1;
    end
    s_tvalid = 2'b00;
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    do_reset();
    tready   = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = {32'h0000_0040, 32'h0000_0030};
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      nacc += $countones(s_tready & s_tvalid);
      if (c >= 2) begin
        checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL bp_full_ready c=%0d got=%b exp=00", c, s_tready); end
        checks++; if (tdata !== 64'h30) begin errors++; $display("FAIL bp_stable c=%0d got=%h exp=30", c, tdata); end
      end
      @(posedge aclk);
      #1;
    end
    checks++; if (nacc !== 2) begin errors++; $display("FAIL bp_accept_count got=%0d exp=2", nacc); end
    s_tvalid = 2'b00;
    tready   = 1'b1;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b1 || tdata !== 64'h30 || dst !== 8'h00) begin errors++; $display("FAIL bp_drain0 got=%b/%h/%h exp=1/30/00", tvalid, tdata, dst); end
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b1 || tdata !== 64'h40 || dst !== 8'h01) begin errors++; $display("FAIL bp_drain1 got=%b/%h/%h exp=1/40/01", tvalid, tdata, dst); end
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", tvalid); end
    tready = 1'b0;
  endtask

  task automatic test_single_stream();
    do_reset();
    tready   = 1'b0;
    s_tvalid = 2'b10;
    s_tdata  = {32'hDEAD_BEEF, 32'h1234_5678};
    @(negedge aclk);
    checks++; if (s_tready !== 2'b10) begin errors++; $display("FAIL single_grant got=%b exp=10", s_tready); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", tvalid); end
    @(posedge aclk);
    #1;
    s_tvalid = 2'b00;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", tvalid); end
    checks++; if (tdata !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=00000000deadbeef", tdata); end
    checks++; if (dst !== 8'h01) begin errors++; $display("FAIL single_dst got=%h exp=01", dst); end
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    tready   = 1'b0;
    s_tdata  = {32'h0000_0070, 32'h0000_0060};
    s_tvalid = 2'b10;
    @(posedge aclk);
    #1;
    s_tvalid = 2'b01;
    @(posedge aclk);
    #1;
    s_tvalid = 2'b11;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b1 || s_tready !== 2'b00) begin errors++; $display("FAIL mid_full got=%b/%b exp=1/00", tvalid, s_tready); end
    arst = 1'b1;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_drop got=%b exp=0", tvalid); end
    checks++; if (tdata !== 64'h0) begin errors++; $display("FAIL mid_async_data got=%h exp=0", tdata); end
    @(posedge aclk);
    #1;
    arst = 1'b0;
    @(negedge aclk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_after_empty got=%b exp=0", tvalid); end
    checks++; if (s_tready !== 2'b01) begin errors++; $display("FAIL mid_after_rr got=%b exp=01", s_tready); end
    s_tvalid = 2'b00;
  endtask

`ifdef LII_PACK_LAST_EN
  task automatic test_packet_lock();
    logic [1:0]  exp_rdy  [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    logic [31:0] exp_data [4] = '{32'h50, 32'h51, 32'h52, 32'h60};
    logic        exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] d0 = 32'h50;
    logic [1:0]  acc;
    do_reset();
    tready   = 1'b1;
    s_tvalid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      s_tdata = {32'h0000_0060, d0};
      s_tlast = {1'b1, (d0 == 32'h52)};
      @(negedge aclk);
      if (c < 4) begin
        checks++; if (s_tready !== exp_rdy[c]) begin errors++; $display("FAIL lock_grant c=%0d got=%b exp=%b", c, s_tready, exp_rdy[c]); end
      end
      if (c > 0) begin
        checks++; if (tdata !== {32'h0, exp_data[c-1]}) begin errors++; $display("FAIL lock_data c=%0d got=%h exp=%h", c, tdata, exp_data[c-1]); end
        checks++; if (tlast !== exp_last[c-1]) begin errors++; $display("FAIL lock_tlast c=%0d got=%b exp=%b", c, tlast, exp_last[c-1]); end
      end
      acc = s_tready & s_tvalid;
      @(posedge aclk);
      #1;
      if (acc[0]) d0 = d0 + 32'd1;
    end
    s_tvalid = 2'b00;
    s_tlast  = 2'b11;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    arst     = 1'b1;
    tready   = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = 64'h0;
`ifdef LII_PACK_LAST_EN
    s_tlast  = 2'b11;
`endif
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_stream();
    test_reset_mid_flight();
`ifdef LII_PACK_LAST_EN
    test_packet_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
